// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing, colour and logo constants
package vga_pkg;

  typedef logic [9:0] coord_t;
  typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_t;

  localparam int H_ACTIVE     = 640;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 752;
  localparam int H_TOTAL      = 800;
  localparam int V_ACTIVE     = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 492;
  localparam int V_TOTAL      = 525;
  localparam int LOGO_SIZE    = 64;
  localparam int X_MAX        = 576;
  localparam int Y_MAX        = 416;

  localparam coord_t BORDER = 10'd4;

  localparam logic [5:0] WHITE    = 6'b111111;
  localparam logic [5:0] RED      = 6'b110000;
  localparam logic [5:0] BLUE     = 6'b000011;
  localparam logic [5:0] BG_GREEN = 6'b000100;
  localparam logic [5:0] BLACK    = 6'b000000;

endpackage

// File: rtl/vga_sync.sv
// rtl/vga_sync.sv - horizontal/vertical counters with sync and active decode
module vga_sync #(
  parameter int H_ACTIVE     = vga_pkg::H_ACTIVE,
  parameter int H_SYNC_START = vga_pkg::H_SYNC_START,
  parameter int H_SYNC_END   = vga_pkg::H_SYNC_END,
  parameter int H_TOTAL      = vga_pkg::H_TOTAL,
  parameter int V_ACTIVE     = vga_pkg::V_ACTIVE,
  parameter int V_SYNC_START = vga_pkg::V_SYNC_START,
  parameter int V_SYNC_END   = vga_pkg::V_SYNC_END,
  parameter int V_TOTAL      = vga_pkg::V_TOTAL
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output vga_pkg::coord_t o_h,
  output vga_pkg::coord_t o_v,
  output logic            o_active,
  output logic            o_hsync_raw,
  output logic            o_vsync_raw
);
  import vga_pkg::*;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT  = coord_t'(V_ACTIVE);
  localparam coord_t H_SS   = coord_t'(H_SYNC_START);
  localparam coord_t H_SE   = coord_t'(H_SYNC_END);
  localparam coord_t V_SS   = coord_t'(V_SYNC_START);
  localparam coord_t V_SE   = coord_t'(V_SYNC_END);

  coord_t r_h;
  coord_t r_v;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + coord_t'(1);
    end else begin
      r_h <= r_h + coord_t'(1);
    end
  end

  assign o_h         = r_h;
  assign o_v         = r_v;
  assign o_active    = (r_h < H_ACT) && (r_v < V_ACT);
  assign o_hsync_raw = !((r_h >= H_SS) && (r_h < H_SE));
  assign o_vsync_raw = !((r_v >= V_SS) && (r_v < V_SE));

endmodule

// File: rtl/vga_top.sv
// rtl/vga_top.sv - VGA bouncing-logo demo: bounce logic, logo pixel function, output registers
module vga_top #(
  parameter int H_ACTIVE     = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE     = vga_pkg::V_ACTIVE,
  parameter int LOGO_SIZE    = vga_pkg::LOGO_SIZE,
  parameter int H_SYNC_START = vga_pkg::H_SYNC_START,
  parameter int H_SYNC_END   = vga_pkg::H_SYNC_END,
  parameter int H_TOTAL      = vga_pkg::H_TOTAL,
  parameter int V_SYNC_START = vga_pkg::V_SYNC_START,
  parameter int V_SYNC_END   = vga_pkg::V_SYNC_END,
  parameter int V_TOTAL      = vga_pkg::V_TOTAL,
  parameter int X_MAX        = vga_pkg::X_MAX,
  parameter int Y_MAX        = vga_pkg::Y_MAX
) (
  input  logic       clk_i,
  input  logic       reset_i,
  output logic       hsync,
  output logic       vsync,
  output logic [5:0] rgb
);
  import vga_pkg::*;

  localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
  localparam coord_t V_UPD   = coord_t'(V_ACTIVE - 1);
  localparam coord_t L_SIZE  = coord_t'(LOGO_SIZE);
  localparam coord_t L_INNER = coord_t'(LOGO_SIZE - 4);
  localparam coord_t X_LIM   = coord_t'(X_MAX);
  localparam coord_t Y_LIM   = coord_t'(Y_MAX);

  coord_t w_h, w_v, w_lx, w_ly, w_nx, w_ny;
  logic   w_active, w_hsync_raw, w_vsync_raw, w_update, w_in_logo;
  logic [5:0] w_pixel;

  coord_t r_x, r_y;
  dir_t   r_dx, r_dy;

  vga_sync #(
    .H_ACTIVE(H_ACTIVE), .H_SYNC_START(H_SYNC_START), .H_SYNC_END(H_SYNC_END), .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE), .V_SYNC_START(V_SYNC_START), .V_SYNC_END(V_SYNC_END), .V_TOTAL(V_TOTAL)
  ) u_sync (
    .i_clk(clk_i), .i_rst_n(reset_i), .o_h(w_h), .o_v(w_v),
    .o_active(w_active), .o_hsync_raw(w_hsync_raw), .o_vsync_raw(w_vsync_raw)
  );

  // Last pixel of the last active line: the logo moves only during vertical blanking.
  assign w_update = (w_h == H_LAST) && (w_v == V_UPD);
  assign w_nx     = (r_dx == DIR_POS) ? r_x + coord_t'(1) : r_x - coord_t'(1);
  assign w_ny     = (r_dy == DIR_POS) ? r_y + coord_t'(1) : r_y - coord_t'(1);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_x  <= '0;
      r_y  <= '0;
      r_dx <= DIR_POS;
      r_dy <= DIR_POS;
    end else if (w_update) begin
      r_x <= w_nx;
      r_y <= w_ny;
      if (w_nx == X_LIM || w_nx == '0) r_dx <= (r_dx == DIR_POS) ? DIR_NEG : DIR_POS;
      if (w_ny == Y_LIM || w_ny == '0) r_dy <= (r_dy == DIR_POS) ? DIR_NEG : DIR_POS;
    end
  end

  function automatic logic [5:0] logo_pixel(input coord_t lx, input coord_t ly);
    if (lx < BORDER || lx >= L_INNER || ly < BORDER || ly >= L_INNER) return WHITE;
    return (lx[3] ^ ly[3]) ? BLUE : RED;
  endfunction

  // Pixels left of / above the logo wrap to large unsigned offsets and fall outside.
  assign w_lx      = w_h - r_x;
  assign w_ly      = w_v - r_y;
  assign w_in_logo = (w_lx < L_SIZE) && (w_ly < L_SIZE);
  assign w_pixel   = !w_active ? BLACK : (w_in_logo ? logo_pixel(w_lx, w_ly) : BG_GREEN);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= BLACK;
    end else begin
      hsync <= w_hsync_raw;
      vsync <= w_vsync_raw;
      rgb   <= w_pixel;
    end
  end

endmodule

// File: tb/tb_vga_top.sv
// tb/tb_vga_top.sv - scoreboard bench for vga_top (full-size and scaled-down instances)
`timescale 1ns/1ps
module tb_vga_top;

  logic clk = 1'b0;
  logic rst_d = 1'b0;
  logic rst_s = 1'b0;
  logic hs_d, vs_d, hs_s, vs_s;
  logic [5:0] rgb_d, rgb_s;

  int checks = 0;
  int errors = 0;

  int HT[2]  = '{800, 40};
  int HA[2]  = '{640, 32};
  int HSS[2] = '{656, 34};
  int HSE[2] = '{752, 38};
  int VT[2]  = '{525, 28};
  int VA[2]  = '{480, 24};
  int VSS[2] = '{490, 25};
  int VSE[2] = '{492, 27};
  int LS[2]  = '{64, 16};
  int XM[2]  = '{576, 16};
  int YM[2]  = '{416, 8};

  always #20.833 clk = ~clk;

  vga_top u_dut (
    .clk_i(clk), .reset_i(rst_d), .hsync(hs_d), .vsync(vs_d), .rgb(rgb_d)
  );

  vga_top #(
    .H_ACTIVE(32), .V_ACTIVE(24), .LOGO_SIZE(16),
    .H_SYNC_START(34), .H_SYNC_END(38), .H_TOTAL(40),
    .V_SYNC_START(25), .V_SYNC_END(27), .V_TOTAL(28),
    .X_MAX(16), .Y_MAX(8)
  ) u_small (
    .clk_i(clk), .reset_i(rst_s), .hsync(hs_s), .vsync(vs_s), .rgb(rgb_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int tri_pos(input int u, input int m);
    int p = u % (2 * m);
    return (p <= m) ? p : 2 * m - p;
  endfunction

  function automatic int upd_count(input int sel, input int n);
    int fr = HT[sel] * VT[sel];
    int m0 = (VA[sel] - 1) * HT[sel] + HT[sel] - 1;
    return (n > m0) ? (n - m0 - 1) / fr + 1 : 0;
  endfunction

  function automatic logic [7:0] exp_out(input int sel, input int n);
    int h = n % HT[sel];
    int v = (n / HT[sel]) % VT[sel];
    int u = upd_count(sel, n);
    int lx = h - tri_pos(u, XM[sel]);
    int ly = v - tri_pos(u, YM[sel]);
    int ls = LS[sel];
    logic hs = !(h >= HSS[sel] && h < HSE[sel]);
    logic vs = !(v >= VSS[sel] && v < VSE[sel]);
    logic [5:0] c;
    if (h >= HA[sel] || v >= VA[sel]) c = 6'b000000;
    else if (lx >= 0 && lx < ls && ly >= 0 && ly < ls) begin
      if (lx < 4 || lx >= ls - 4 || ly < 4 || ly >= ls - 4) c = 6'b111111;
      else if ((((lx / 8) ^ (ly / 8)) & 1) == 0) c = 6'b110000;
      else c = 6'b000011;
    end else c = 6'b000100;
    return {hs, vs, c};
  endfunction

  // Hand-picked pixels with fixed expected colours; -1 means no spot check here.
  function automatic int pix_exp(input int sel, input int u, input int h, input int v);
    if (sel == 0) begin
      if (h == 0 && v == 0) return 63;
      if (h == 4 && v == 4) return 48;
      if (h == 12 && v == 4) return 3;
      if (h == 64 && v == 0) return 4;
      if (h == 640 && v == 0) return 0;
    end else begin
      if (u == 0 && h == 0 && v == 0) return 63;
      if (u == 0 && h == 4 && v == 4) return 48;
      if (u == 1 && h == 0 && v == 0) return 4;
      if (u == 1 && h == 1 && v == 1) return 63;
      if (u == 9 && h == 9 && v == 7) return 63;
      if (u == 9 && h == 9 && v == 6) return 4;
      if (u == 16 && h == 16 && v == 0) return 63;
      if (u == 16 && h == 15 && v == 0) return 4;
      if (u == 17 && h == 15 && v == 1) return 63;
      if (u == 17 && h == 15 && v == 0) return 4;
    end
    return -1;
  endfunction

  task automatic run_trace(input int sel, input int ncyc,
                           output int hf1, output int hr1, output int hf2,
                           output int vf1, output int vr1, output int vf2);
    logic [7:0] q[$];
    logic [7:0] obs, e;
    logic prev_hs = 1'b1, prev_vs = 1'b1;
    int nhf = 0, nvf = 0, n, px;
    hf1 = 0; hr1 = 0; hf2 = 0; vf1 = 0; vr1 = 0; vf2 = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      q.push_back(exp_out(sel, k - 1));
      @(negedge clk);
      obs = (sel == 0) ? {hs_d, vs_d, rgb_d} : {hs_s, vs_s, rgb_s};
      e = q.pop_front();
      check($sformatf("trace%0d_n%0d", sel, k - 1), obs, e);
      n = k - 1;
      px = pix_exp(sel, upd_count(sel, n), n % HT[sel], (n / HT[sel]) % VT[sel]);
      if (px >= 0)
        check($sformatf("pix%0d_h%0d_v%0d", sel, n % HT[sel], (n / HT[sel]) % VT[sel]), obs[5:0], px);
      if (prev_hs && !obs[7]) begin
        nhf++;
        if (nhf == 1) hf1 = k; else if (nhf == 2) hf2 = k;
      end
      if (!prev_hs && obs[7] && nhf == 1) hr1 = k;
      if (prev_vs && !obs[6]) begin
        nvf++;
        if (nvf == 1) vf1 = k; else if (nvf == 2) vf2 = k;
      end
      if (!prev_vs && obs[6] && nvf == 1) vr1 = k;
      prev_hs = obs[7];
      prev_vs = obs[6];
    end
  endtask

  initial begin
    int hf1, hr1, hf2, vf1, vr1, vf2;
    int found;
    #50;
    check("rst_hsync_d", hs_d, 1);
    check("rst_vsync_d", vs_d, 1);
    check("rst_rgb_d", rgb_d, 0);
    check("rst_hsync_s", hs_s, 1);
    check("rst_rgb_s", rgb_s, 0);
    repeat (3) @(negedge clk);
    rst_d = 1'b1;

    run_trace(0, 4000, hf1, hr1, hf2, vf1, vr1, vf2);
    check("hs_first_fall", hf1, 657);
    check("hs_low_len", hr1 - hf1, 96);
    check("hs_period", hf2 - hf1, 800);
    check("small_held_rgb", rgb_s, 0);
    check("small_held_vsync", vs_s, 1);

    rst_s = 1'b1;
    run_trace(1, 20200, hf1, hr1, hf2, vf1, vr1, vf2);
    check("hs_period_s", hf2 - hf1, 40);
    check("vs_first_fall_s", vf1, 1001);
    check("vs_low_len_s", vr1 - vf1, 80);
    check("vs_period_s", vf2 - vf1, 1120);

    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (rgb_s != 6'b0 && hs_s) found = 1;
    end
    check("mid_active_found", found, 1);
    #5 rst_s = 1'b0;
    #1;
    check("async_rst_rgb", rgb_s, 0);
    check("async_rst_hsync", hs_s, 1);
    check("async_rst_vsync", vs_s, 1);
    repeat (3) @(negedge clk);
    check("async_rst_hold_rgb", rgb_s, 0);
    rst_s = 1'b1;
    run_trace(1, 200, hf1, hr1, hf2, vf1, vr1, vf2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
